regfile_rename: RTL and testbench
=================================

# regfile_rename

Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer's commit port and beside the issue stage. Issue reads source operands (value, or the producing ROB entry if still in flight) and renames the destination to the newly allocated ROB entry. The ROB commit stream writes retired results and clears tags. Rollback discards all in-flight renames.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers (x0 hard-wired zero)
- ENTRY_W, 6, width of a ROB entry tag
- ENTRY_NULL, 6'd32, tag value meaning "no pending producer"

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; when low, all state holds
- rollback  in  1  misprediction flush, same cycle as the ROB flush
- issue_valid  in  1  issue stage allocates an instruction this cycle
- issue_rd  in  5  destination register of the issuing instruction
- issue_entry  in  ENTRY_W  ROB entry allocated to it
- rs1_idx, rs2_idx  in  5 each  source register indices
- rs1_val, rs2_val  out  32 each  operand value (valid when busy low)
- rs1_tag, rs2_tag  out  ENTRY_W each  producing ROB entry, ENTRY_NULL if none
- rs1_busy, rs2_busy  out  1 each  operand still pending
- commit_sgn  in  1  ROB retires a register-writing instruction
- commit_entry  in  ENTRY_W  retiring ROB entry
- commit_rd  in  6  destination field from ROB; bit 5 ignored, [4:0] used
- commit_value  in  32  result to write
- pending_cnt  out  6  number of registers currently busy
- retire_cnt  out  32  count of commits that wrote a nonzero register

## Operation
- State per register i: val[i] (32), tag[i] (ENTRY_W), busy[i] (1).
- Read (combinational), per source s with index k:
  - k==0: val=0, tag=ENTRY_NULL, busy=0.
  - busy[k] and commit_sgn and commit_entry==tag[k]: bypass; val=commit_value, busy=0, tag=ENTRY_NULL.
  - busy[k] otherwise: val=val[k], tag=tag[k], busy=1.
  - otherwise: val=val[k], tag=ENTRY_NULL, busy=0.
  - Reads see pre-rename state. An instruction reading its own rd (add x1,x1,x2) gets the old producer, not itself.
- Commit (clk edge, rdy high, no rollback/rst), when commit_sgn and commit_rd[4:0]!=0:
  - val[rd] <= commit_value; retire_cnt += 1.
  - If tag[rd]==commit_entry and not renamed this cycle: busy[rd] <= 0, tag[rd] <= ENTRY_NULL.
  - If tag[rd]!=commit_entry, a younger producer owns rd: only val is written; busy and tag unchanged.
- Issue (same edge), when issue_valid and issue_rd!=0: tag[rd] <= issue_entry, busy[rd] <= 1. Issue and commit hitting the same rd in one cycle: val takes commit_value, and tag/busy take the issue update (issue wins).
- x0: never written, never busy; commits and issues to x0 are ignored, and retire_cnt does not increment.
- Rollback (edge, rdy high): all busy <= 0, all tag <= ENTRY_NULL, val kept. A commit or issue presented in the same cycle is ignored. The ROB flushes in the same cycle, so nothing may retire.
- rst: all val <= 0, busy <= 0, tag <= ENTRY_NULL, retire_cnt <= 0. rst dominates rollback and rdy.
- rdy low: no state changes; reads remain combinational on held state.
- pending_cnt: registered popcount of busy, updated on the same edge as busy; range 0..31.

## Timing
- Read latency: 0 cycles (combinational from rs*_idx and commit inputs).
- Write/rename latency: 1 edge; visible to reads the next cycle. Same-cycle commit results reach reads through the bypass.
- Reset values: rs*_val=0, rs*_tag=ENTRY_NULL, rs*_busy=0, pending_cnt=0, retire_cnt=0.
- No handshake back-pressure: issue_valid is accepted whenever rdy is high. The issue stage guarantees the ROB is not full.
- Commit inputs are the ROB's registered outputs. commit_sgn is a single-cycle pulse per retired instruction.

## Test plan
- Reset then read x5: val=0, busy=0, tag=32. Commit rd=5, value 0x1234, entry 3 -> next cycle x5 val=0x1234, busy=0, retire_cnt=1.
- Issue rd=7 entry 4 -> next cycle rs1_idx=7 gives busy=1, tag=4, pending_cnt=1. In the cycle commit entry 4 with value 0xAB is presented, the read shows val=0xAB, busy=0 (bypass). The next cycle shows busy=0 and pending_cnt=0.
- Issue rd=9 entry 1, then issue rd=9 entry 2, then commit entry 1 value 0x11 -> x9 stays busy with tag=2 and val=0x11. Commit entry 2 value 0x22 -> busy=0, val=0x22.
- Same cycle: issue rd=3 entry 6 and commit rd=3 entry 5 (tag[3]=5) value 0x55 -> next cycle val=0x55, busy=1, tag=6.
- Issue rd=0 and commit rd=0 value 0xFF -> x0 reads 0, busy=0, retire_cnt unchanged. rs1_idx=rs2_idx=0 -> both val=0.
- Registers 1, 2 and 10 are busy. Assert rollback together with commit_sgn for x1 -> next cycle all busy=0, tags=ENTRY_NULL, pending_cnt=0, values unchanged. With rdy low during an issue, no change occurs.

Source files
------------

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags.
// Issue reads and renames; the ROB commit stream writes values and clears tags.
module regfile_rename #(
    parameter int                 REG_NUM    = 32,
    parameter int                 ENTRY_W    = 6,
    parameter logic [ENTRY_W-1:0] ENTRY_NULL = 6'd32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rollback,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rd,
    input  logic [ENTRY_W-1:0] issue_entry,
    input  logic [4:0]         rs1_idx,
    input  logic [4:0]         rs2_idx,
    output logic [31:0]        rs1_val,
    output logic [31:0]        rs2_val,
    output logic [ENTRY_W-1:0] rs1_tag,
    output logic [ENTRY_W-1:0] rs2_tag,
    output logic               rs1_busy,
    output logic               rs2_busy,
    input  logic               commit_sgn,
    input  logic [ENTRY_W-1:0] commit_entry,
    input  logic [5:0]         commit_rd,
    input  logic [31:0]        commit_value,
    output logic [5:0]         pending_cnt,
    output logic [31:0]        retire_cnt
);

    typedef struct packed {
        logic [31:0]        val;
        logic [ENTRY_W-1:0] tag;
        logic               busy;
    } src_t;

    logic [31:0]        val      [REG_NUM];
    logic [ENTRY_W-1:0] tag      [REG_NUM];
    logic [ENTRY_W-1:0] tag_next [REG_NUM];
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_next;
    logic [5:0]         cnt_next;
    logic [4:0]         commit_idx;
    logic               commit_hit;
    logic               issue_hit;
    logic [4:0]         src_idx  [2];

    assign commit_idx = commit_rd[4:0];
    assign commit_hit = commit_sgn && (commit_idx != 5'd0);
    assign issue_hit  = issue_valid && (issue_rd != 5'd0);
    assign src_idx[0] = rs1_idx;
    assign src_idx[1] = rs2_idx;

    // Operand read with same-cycle commit bypass; sees pre-rename state.
    for (genvar s = 0; s < 2; s++) begin : g_src
        src_t res;
        always_comb begin
            res = '{val: val[src_idx[s]], tag: ENTRY_NULL, busy: 1'b0};
            if (src_idx[s] == 5'd0)
                res = '{val: 32'd0, tag: ENTRY_NULL, busy: 1'b0};
            else if (busy[src_idx[s]] && commit_sgn && commit_entry == tag[src_idx[s]])
                res = '{val: commit_value, tag: ENTRY_NULL, busy: 1'b0};
            else if (busy[src_idx[s]])
                res = '{val: val[src_idx[s]], tag: tag[src_idx[s]], busy: 1'b1};
        end
    end

    assign rs1_val  = g_src[0].res.val;
    assign rs1_tag  = g_src[0].res.tag;
    assign rs1_busy = g_src[0].res.busy;
    assign rs2_val  = g_src[1].res.val;
    assign rs2_tag  = g_src[1].res.tag;
    assign rs2_busy = g_src[1].res.busy;

    // Next tag/busy; the issue update is applied last so it wins over a commit clear.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            busy_next[i] = busy[i];
            tag_next[i]  = tag[i];
        end
        for (int i = 1; i < REG_NUM; i++) begin
            if (rollback) begin
                busy_next[i] = 1'b0;
                tag_next[i]  = ENTRY_NULL;
            end else begin
                if (commit_hit && commit_idx == 5'(i) && tag[i] == commit_entry) begin
                    busy_next[i] = 1'b0;
                    tag_next[i]  = ENTRY_NULL;
                end
                if (issue_hit && issue_rd == 5'(i)) begin
                    busy_next[i] = 1'b1;
                    tag_next[i]  = issue_entry;
                end
            end
        end
        busy_next[0] = 1'b0;
        tag_next[0]  = ENTRY_NULL;
    end

    always_comb begin
        cnt_next = 6'd0;
        for (int i = 0; i < REG_NUM; i++)
            cnt_next = cnt_next + 6'(busy_next[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val[i] <= 32'd0;
                tag[i] <= ENTRY_NULL;
            end
            busy        <= '0;
            pending_cnt <= 6'd0;
            retire_cnt  <= 32'd0;
        end else if (rdy) begin
            for (int i = 0; i < REG_NUM; i++)
                tag[i] <= tag_next[i];
            busy        <= busy_next;
            pending_cnt <= cnt_next;
            // The ROB flushes alongside rollback, so a coincident commit is dropped.
            if (!rollback && commit_hit) begin
                val[commit_idx] <= commit_value;
                retire_cnt      <= retire_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed-vector bench for regfile_rename with a queue-based scoreboard.
module tb_regfile_rename;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, issue_valid, commit_sgn;
    logic [4:0]  issue_rd, rs1_idx, rs2_idx;
    logic [5:0]  issue_entry, commit_entry, commit_rd;
    logic [31:0] commit_value;
    logic [31:0] rs1_val, rs2_val, retire_cnt;
    logic [5:0]  rs1_tag, rs2_tag, pending_cnt;
    logic        rs1_busy, rs2_busy;

    typedef struct {
        string       name;
        logic [31:0] v1; logic [5:0] t1; logic b1;
        logic [31:0] v2; logic [5:0] t2; logic b2;
        logic [5:0]  pend;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];
    logic sample = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    regfile_rename dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_entry(issue_entry),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .commit_sgn(commit_sgn), .commit_entry(commit_entry),
        .commit_rd(commit_rd), .commit_value(commit_value),
        .pending_cnt(pending_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expectation per sampled cycle, away from the active edge.
    always @(negedge clk) begin
        if (sample) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underflow: sample strobe with no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if (rs1_val !== e.v1 || rs1_tag !== e.t1 || rs1_busy !== e.b1 ||
                    rs2_val !== e.v2 || rs2_tag !== e.t2 || rs2_busy !== e.b2 ||
                    pending_cnt !== e.pend || retire_cnt !== e.ret) begin
                    miscompares++;
                    $display("FAIL %s: got rs1=%h/%0d/%b rs2=%h/%0d/%b pend=%0d ret=%0d, want rs1=%h/%0d/%b rs2=%h/%0d/%b pend=%0d ret=%0d",
                             e.name, rs1_val, rs1_tag, rs1_busy, rs2_val, rs2_tag, rs2_busy,
                             pending_cnt, retire_cnt, e.v1, e.t1, e.b1, e.v2, e.t2, e.b2,
                             e.pend, e.ret);
                end
            end
        end
    end

    task automatic want(input string name,
                        input logic [31:0] v1, input logic [5:0] t1, input logic b1,
                        input logic [31:0] v2, input logic [5:0] t2, input logic b2,
                        input logic [5:0] pend, input logic [31:0] ret);
        exp_t e;
        e = '{name: name, v1: v1, t1: t1, b1: b1, v2: v2, t2: t2, b2: b2, pend: pend, ret: ret};
        exp_q.push_back(e);
        sample = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sample      = 1'b0;
        rst         = 1'b0;
        rdy         = 1'b1;
        rollback    = 1'b0;
        issue_valid = 1'b0;
        commit_sgn  = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [5:0] entry);
        issue_valid = 1'b1; issue_rd = rd; issue_entry = entry;
    endtask

    task automatic commit(input logic [5:0] rd, input logic [5:0] entry, input logic [31:0] value);
        commit_sgn = 1'b1; commit_rd = rd; commit_entry = entry; commit_value = value;
    endtask

    localparam logic [5:0] NUL = 6'd32;

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue_valid = 1'b0; commit_sgn = 1'b0;
        issue_rd = 5'd0; issue_entry = 6'd0; commit_rd = 6'd0; commit_entry = 6'd0;
        commit_value = 32'd0; rs1_idx = 5'd0; rs2_idx = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        step();

        rs1_idx = 5; rs2_idx = 0;
        want("reset_state", 0, NUL, 0, 0, NUL, 0, 0, 0); step();
        rs1_idx = 5; commit(6'd5, 6'd3, 32'h1234);
        want("commit_x5_pre", 0, NUL, 0, 0, NUL, 0, 0, 0); step();
        rs1_idx = 5;
        want("commit_x5_post", 32'h1234, NUL, 0, 0, NUL, 0, 0, 1); step();

        rs1_idx = 7; issue(5'd7, 6'd4);
        want("issue_x7_pre", 0, NUL, 0, 0, NUL, 0, 0, 1); step();
        rs1_idx = 7;
        want("issue_x7_busy", 0, 6'd4, 1, 0, NUL, 0, 1, 1); step();
        rs1_idx = 7; rs2_idx = 5; commit(6'd7, 6'd4, 32'hAB);
        want("bypass_x7", 32'hAB, NUL, 0, 32'h1234, NUL, 0, 1, 1); step();
        rs1_idx = 7; rs2_idx = 0;
        want("x7_retired", 32'hAB, NUL, 0, 0, NUL, 0, 0, 2); step();

        rs1_idx = 9; issue(5'd9, 6'd1);
        want("issue_x9_e1", 0, NUL, 0, 0, NUL, 0, 0, 2); step();
        rs1_idx = 9; issue(5'd9, 6'd2);
        want("issue_x9_e2", 0, 6'd1, 1, 0, NUL, 0, 1, 2); step();
        rs1_idx = 9; rs2_idx = 7; commit(6'd9, 6'd1, 32'h11);
        want("stale_commit_no_bypass", 0, 6'd2, 1, 32'hAB, NUL, 0, 1, 2); step();
        rs1_idx = 9; rs2_idx = 0;
        want("stale_commit_val_only", 32'h11, 6'd2, 1, 0, NUL, 0, 1, 3); step();
        rs1_idx = 9; commit(6'd9, 6'd2, 32'h22);
        want("young_commit_bypass", 32'h22, NUL, 0, 0, NUL, 0, 1, 3); step();
        rs1_idx = 9;
        want("young_commit_post", 32'h22, NUL, 0, 0, NUL, 0, 0, 4); step();

        issue(5'd3, 6'd5); step();
        rs1_idx = 3; issue(5'd3, 6'd6); commit(6'd3, 6'd5, 32'h55);
        want("issue_commit_same_rd", 32'h55, NUL, 0, 0, NUL, 0, 1, 4); step();
        rs1_idx = 3;
        want("issue_wins_tag", 32'h55, 6'd6, 1, 0, NUL, 0, 1, 5); step();

        rs1_idx = 0; rs2_idx = 0; issue(5'd0, 6'd7); commit(6'h20, 6'd9, 32'hFF);
        want("x0_writes", 0, NUL, 0, 0, NUL, 0, 1, 5); step();
        rs1_idx = 0; rs2_idx = 3;
        want("x0_ignored", 0, NUL, 0, 32'h55, 6'd6, 1, 1, 5); step();

        issue(5'd1, 6'd10); step();
        issue(5'd2, 6'd11); step();
        rs1_idx = 1; rs2_idx = 2; issue(5'd10, 6'd12);
        want("busy_set", 0, 6'd10, 1, 0, 6'd11, 1, 3, 5); step();
        rs1_idx = 1; rs2_idx = 10; rollback = 1'b1;
        commit(6'd1, 6'd10, 32'h99); issue(5'd11, 6'd13);
        want("rollback_cycle", 32'h99, NUL, 0, 0, 6'd12, 1, 4, 5); step();
        rs1_idx = 1; rs2_idx = 10;
        want("rollback_clears", 0, NUL, 0, 0, NUL, 0, 0, 5); step();
        rs1_idx = 3; rs2_idx = 11;
        want("rollback_keeps_val", 32'h55, NUL, 0, 0, NUL, 0, 0, 5); step();

        rdy = 1'b0; rs1_idx = 4; rs2_idx = 5; issue(5'd4, 6'd14); commit(6'd5, 6'd3, 32'h77);
        want("rdy_low_cycle", 0, NUL, 0, 32'h1234, NUL, 0, 0, 5); step();
        rs1_idx = 4; rs2_idx = 5;
        want("rdy_low_holds", 0, NUL, 0, 32'h1234, NUL, 0, 0, 5); step();

        rst = 1'b1; rdy = 1'b0; rs1_idx = 5; rs2_idx = 7;
        want("pre_reset", 32'h1234, NUL, 0, 32'hAB, NUL, 0, 0, 5); step();
        rs1_idx = 5; rs2_idx = 7;
        want("reset_dominates", 0, NUL, 0, 0, NUL, 0, 0, 0); step();

        step();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: %0d expectations never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
